linked_list_fifo_sched: RTL and testbench

Scheduler placed in front of the shared-memory linked-list FIFO, whose N FIFOs share DEPTH entries. It arbitrates N producer valid/ready streams onto the FIFO's one-hot push port, choosing round-robin among requesters. It also drains non-empty FIFOs round-robin into a single registered valid/ready output stream. The block guarantees the FIFO's contract: push and pop are each zero or one-hot, never both in one cycle, no push when full, and no pop from an empty FIFO.

---
 rtl/linked_list_fifo_sched.sv | 155 +++++++++++++++
 tb/tb_linked_list_fifo_sched.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linked_list_fifo_sched.sv
// Round-robin scheduler in front of a shared-memory linked-list FIFO.
// Arbitrates N producer streams onto the FIFO push port and drains
// non-empty FIFOs into one registered output stream. Push and pop alternate
// under contention and are never issued in the same cycle.
`timescale 1ns/1ps
module linked_list_fifo_sched #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int ID_WIDTH  = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FIFOS-1:0]       in_valid,
  input  logic [NUM_FIFOS*WIDTH-1:0] in_data,
  output logic [NUM_FIFOS-1:0]       in_ready,
  input  logic [NUM_FIFOS-1:0]       pop_mask,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [ID_WIDTH-1:0]        out_fifo,
  input  logic                       out_ready,
  output logic [NUM_FIFOS-1:0]       fifo_push,
  output logic [NUM_FIFOS-1:0]       fifo_pop,
  output logic [WIDTH-1:0]           fifo_data_in,
  input  logic                       fifo_full,
  input  logic [NUM_FIFOS-1:0]       fifo_empty,
  input  logic [WIDTH-1:0]           fifo_data_out
);

  // A zero-depth FIFO can never take a word.
  localparam bit HasStorage = (DEPTH > 0);

  logic [ID_WIDTH-1:0] push_ptr_q, push_ptr_d;
  logic [ID_WIDTH-1:0] pop_ptr_q, pop_ptr_d;
  logic                prio_q, prio_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [ID_WIDTH-1:0] out_fifo_q, out_fifo_d;

  logic [NUM_FIFOS-1:0] pop_req;
  logic [ID_WIDTH-1:0]  push_idx, pop_idx, data_sel;
  logic                 push_found, pop_found;
  logic                 push_elig, pop_elig, push_go, pop_go;

  // Pointer increment that wraps N-1 -> 0, so index N is never produced.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] p);
    if (p == ID_WIDTH'(NUM_FIFOS - 1)) return '0;
    return p + ID_WIDTH'(1);
  endfunction

  assign pop_req = ~fifo_empty & ~pop_mask;

  // First requesting producer at or after push_ptr, wrapping.
  always_comb begin : push_search
    logic [ID_WIDTH-1:0] cand;
    push_found = 1'b0;
    push_idx   = push_ptr_q;
    cand       = push_ptr_q;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      if (!push_found && in_valid[cand]) begin
        push_found = 1'b1;
        push_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // First unmasked non-empty FIFO at or after pop_ptr, wrapping.
  always_comb begin : pop_search
    logic [ID_WIDTH-1:0] cand;
    pop_found = 1'b0;
    pop_idx   = pop_ptr_q;
    cand      = pop_ptr_q;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      if (!pop_found && pop_req[cand]) begin
        pop_found = 1'b1;
        pop_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Eligibility and the push/pop phase decision; only one side issues.
  always_comb begin
    push_elig = HasStorage && !rst && push_found && !fifo_full;
    pop_elig  = !rst && pop_found && (!out_valid_q || out_ready);
    push_go   = push_elig && (!pop_elig || !prio_q);
    pop_go    = pop_elig && (!push_elig || prio_q);
  end

  // One-hot strobes toward the FIFO and back to the producers.
  always_comb begin
    fifo_push = push_go ? (NUM_FIFOS'(1) << push_idx) : '0;
    fifo_pop  = pop_go  ? (NUM_FIFOS'(1) << pop_idx)  : '0;
    in_ready  = fifo_push;
  end

  // Data mux: granted slice on a push, the push_ptr slice when idle.
  always_comb begin
    data_sel     = push_go ? push_idx : push_ptr_q;
    fifo_data_in = '0;
    if (!rst) begin
      for (int k = 0; k < NUM_FIFOS; k++) begin
        if (data_sel == ID_WIDTH'(k)) fifo_data_in = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for pointers, phase bit and the output holding register.
  always_comb begin
    push_ptr_d  = push_ptr_q;
    pop_ptr_d   = pop_ptr_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_fifo_d  = out_fifo_q;
    if (push_go) begin
      push_ptr_d = wrap_inc(push_idx);
      prio_d     = 1'b1;
    end
    if (pop_go) begin
      pop_ptr_d   = wrap_inc(pop_idx);
      prio_d      = 1'b0;
      out_valid_d = 1'b1;
      out_data_d  = fifo_data_out;
      out_fifo_d  = pop_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_fifo_q  <= '0;
    end else begin
      push_ptr_q  <= push_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_fifo_q  <= out_fifo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_fifo  = out_fifo_q;

endmodule

// File: tb/tb_linked_list_fifo_sched.sv
// Testbench for linked_list_fifo_sched with a behavioural shared FIFO and
// a per-FIFO ordering scoreboard.
`timescale 1ns/1ps
module tb_linked_list_fifo_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid, in_ready, pop_mask, fifo_push, fifo_pop, fifo_empty;
  logic [15:0] in_data;
  logic        out_valid, out_ready, fifo_full;
  logic [7:0]  out_data, fifo_data_in, fifo_data_out;
  logic        out_fifo;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] src0[$], src1[$], exp0[$], exp1[$], acc_data[$];
  int         acc_fifo[$], push_log[$];
  int         pop_cnt = 0;

  linked_list_fifo_sched #(.WIDTH(8), .DEPTH(4), .NUM_FIFOS(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pop_mask(pop_mask),
    .out_valid(out_valid), .out_data(out_data), .out_fifo(out_fifo), .out_ready(out_ready),
    .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out)
  );

  always #5 clk = ~clk;

  // Shared-storage FIFO model: 2 queues, 4 entries total.
  logic [7:0] fmem [2][4];
  int         fcnt [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt[0] <= 0;
      fcnt[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fifo_push[i] && fcnt[i] < 4) begin
          fmem[i][fcnt[i]] <= fifo_data_in;
          fcnt[i] <= fcnt[i] + 1;
        end else if (fifo_pop[i] && fcnt[i] > 0) begin
          for (int k = 0; k < 3; k++) fmem[i][k] <= fmem[i][k+1];
          fcnt[i] <= fcnt[i] - 1;
        end
      end
    end
  end

  assign fifo_full  = (fcnt[0] + fcnt[1]) >= 4;
  assign fifo_empty = {fcnt[1] == 0, fcnt[0] == 0};

  always_comb begin
    fifo_data_out = 8'h00;
    if (fifo_pop[0] && fcnt[0] > 0) fifo_data_out = fmem[0][0];
    else if (fifo_pop[1] && fcnt[1] > 0) fifo_data_out = fmem[1][0];
  end

  // Per-cycle contract checks, push/accept logging and scoreboard.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    logic       have;
    tests_run++;
    if (rst) begin
      if (in_ready !== 2'b00 || fifo_push !== 2'b00 || fifo_pop !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_strobes: in_ready=%b push=%b pop=%b, required all 0", in_ready, fifo_push, fifo_pop);
      end
      exp0.delete(); exp1.delete(); acc_data.delete(); acc_fifo.delete(); push_log.delete();
      pop_cnt = 0;
    end else begin
      if ((fifo_push & (fifo_push - 2'd1)) != 0 || (fifo_pop & (fifo_pop - 2'd1)) != 0 ||
          (fifo_push != 0 && fifo_pop != 0) || (fifo_push != 0 && fifo_full) ||
          (fifo_pop & fifo_empty) != 0 || in_ready !== fifo_push || (in_ready & ~in_valid) != 0) begin
        tests_failed++;
        $display("FAIL contract: push=%b pop=%b in_ready=%b in_valid=%b full=%b empty=%b, required legal one-hot strobes",
                 fifo_push, fifo_pop, in_ready, in_valid, fifo_full, fifo_empty);
      end
      if (in_valid[0] && in_ready[0]) begin push_log.push_back(0); exp0.push_back(in_data[7:0]); end
      if (in_valid[1] && in_ready[1]) begin push_log.push_back(1); exp1.push_back(in_data[15:8]); end
      if (fifo_pop != 0) pop_cnt++;
      if (out_valid && out_ready) begin
        tests_run++;
        have = 1'b0;
        e = 8'h00;
        if (!out_fifo && exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
        else if (out_fifo && exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
        if (!have || out_data !== e) begin
          tests_failed++;
          $display("FAIL scoreboard: got data %h from fifo %0d, required %h (expected word present=%0d)",
                   out_data, out_fifo, e, have);
        end
        acc_data.push_back(out_data);
        acc_fifo.push_back(int'(out_fifo));
      end
    end
  end

  task automatic drive_inputs();
    in_valid[0]   = src0.size() > 0;
    in_valid[1]   = src1.size() > 0;
    in_data[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
    in_data[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
  endtask

  // One clock; producers advance on handshake. Returns at posedge+1.
  task automatic cycle();
    logic [1:0] hs;
    @(negedge clk);
    hs = in_valid & in_ready;
    @(posedge clk);
    #1;
    if (hs[0] && src0.size() > 0) void'(src0.pop_front());
    if (hs[1] && src1.size() > 0) void'(src1.pop_front());
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src0.delete(); src1.delete();
    drive_inputs();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 2'b00 || fifo_push !== 2'b00 || fifo_pop !== 2'b00) begin
        tests_failed++;
        $display("FAIL idle_after_reset: out_valid=%b in_ready=%b push=%b pop=%b, required all 0", out_valid, in_ready, fifo_push, fifo_pop);
      end
    end
    out_ready = 1'b0;
    src0.push_back(8'h5A);
    drive_inputs();
    cycle(); cycle();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL reset_precondition: out_valid=%b data=%h, required 1 5a", out_valid, out_data);
    end
    src0.push_back(8'h6B);
    drive_inputs();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_fifo !== 1'b0 || fifo_push !== 2'b00 ||
        fifo_pop !== 2'b00 || in_ready !== 2'b00) begin
      tests_failed++;
      $display("FAIL async_reset: out_valid=%b data=%h fifo=%b push=%b pop=%b in_ready=%b, required all 0",
               out_valid, out_data, out_fifo, fifo_push, fifo_pop, in_ready);
    end
    src0.delete();
    drive_inputs();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests_run++;
      if (out_valid !== 1'b0 || fifo_push !== 2'b00 || fifo_pop !== 2'b00) begin
        tests_failed++;
        $display("FAIL idle_after_midreset: out_valid=%b push=%b pop=%b, required all 0", out_valid, fifo_push, fifo_pop);
      end
    end
  endtask

  task automatic test_single_stream();
    logic [7:0] expv [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    out_ready = 1'b1;
    pop_mask  = 2'b00;
    src0.push_back(8'h11); src0.push_back(8'h22); src0.push_back(8'h33);
    drive_inputs();
    cycle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_edge1: out_valid=%b, required 0", out_valid);
    end
    cycle();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_fifo !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_edge2: out_valid=%b data=%h fifo=%b, required 1 11 0", out_valid, out_data, out_fifo);
    end
    for (int c = 0; c < 30 && acc_data.size() < 3; c++) cycle();
    tests_run++;
    if (acc_data.size() != 3) begin
      tests_failed++;
      $display("FAIL single_count: got %0d words, required 3", acc_data.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (acc_data[k] !== expv[k] || acc_fifo[k] != 0) begin
          tests_failed++;
          $display("FAIL single_word%0d: got %h fifo %0d, required %h fifo 0", k, acc_data[k], acc_fifo[k], expv[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] expd [5] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2};
    int         expf [5] = '{0, 1, 0, 1, 0};
    do_reset();
    out_ready = 1'b0;
    pop_mask  = 2'b00;
    for (int k = 0; k < 6; k++) begin
      src0.push_back(8'(8'hA0 + k));
      src1.push_back(8'(8'hB0 + k));
    end
    drive_inputs();
    repeat (20) cycle();
    tests_run++;
    if (push_log.size() != 5) begin
      tests_failed++;
      $display("FAIL rr_push_count: got %0d pushes, required 5", push_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (push_log[k] != expf[k]) begin
          tests_failed++;
          $display("FAIL rr_push_order%0d: got fifo %0d, required %0d", k, push_log[k], expf[k]);
        end
      end
    end
    tests_run++;
    if (pop_cnt != 1 || in_ready !== 2'b00 || fifo_full !== 1'b1 || out_valid !== 1'b1 ||
        out_data !== 8'hA0 || out_fifo !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_full_state: pops=%0d in_ready=%b full=%b out_valid=%b data=%h fifo=%b, required 1 00 1 1 a0 0",
               pop_cnt, in_ready, fifo_full, out_valid, out_data, out_fifo);
    end
    src0.delete(); src1.delete();
    drive_inputs();
    out_ready = 1'b1;
    for (int c = 0; c < 30 && acc_data.size() < 5; c++) cycle();
    tests_run++;
    if (acc_data.size() != 5) begin
      tests_failed++;
      $display("FAIL rr_drain_count: got %0d words, required 5", acc_data.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (acc_data[k] !== expd[k] || acc_fifo[k] != expf[k]) begin
          tests_failed++;
          $display("FAIL rr_drain%0d: got %h fifo %0d, required %h fifo %0d", k, acc_data[k], acc_fifo[k], expd[k], expf[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] prev;
    do_reset();
    pop_mask  = 2'b00;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) src1.push_back(8'(k));
    drive_inputs();
    repeat (8) cycle();
    tests_run++;
    if (push_log.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_fill: got %0d pushes, required 4", push_log.size());
    end
    for (int k = 0; k < 40 && acc_data.size() < 4; k++) begin
      out_ready = (k % 2 == 0);
      if (!out_ready && out_valid) begin
        prev = out_data;
        cycle();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== prev || out_fifo !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_hold: out_valid=%b data=%h fifo=%b, required 1 %h 1", out_valid, out_data, out_fifo, prev);
        end
      end else begin
        cycle();
      end
    end
    tests_run++;
    if (acc_data.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d words, required 4", acc_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (acc_data[k] !== 8'(k + 1) || acc_fifo[k] != 1) begin
          tests_failed++;
          $display("FAIL bp_word%0d: got %h fifo %0d, required %h fifo 1", k, acc_data[k], acc_fifo[k], 8'(k + 1));
        end
      end
    end
  endtask

  task automatic test_pop_mask();
    do_reset();
    out_ready = 1'b1;
    pop_mask  = 2'b11;
    src0.push_back(8'h55);
    src1.push_back(8'h66);
    drive_inputs();
    repeat (4) cycle();
    tests_run++;
    if (push_log.size() != 2 || pop_cnt != 0) begin
      tests_failed++;
      $display("FAIL mask_fill: pushes=%0d pops=%0d, required 2 0", push_log.size(), pop_cnt);
    end
    pop_mask = 2'b01;
    repeat (6) cycle();
    tests_run++;
    if (acc_data.size() != 1 || acc_data[0] !== 8'h66 || acc_fifo[0] != 1) begin
      tests_failed++;
      $display("FAIL mask_only66: got %0d words first %h, required 1 word 66 from fifo 1",
               acc_data.size(), (acc_data.size() > 0) ? acc_data[0] : 8'h00);
    end
    pop_mask = 2'b00;
    repeat (6) cycle();
    tests_run++;
    if (acc_data.size() != 2 || acc_data[1] !== 8'h55 || acc_fifo[1] != 0) begin
      tests_failed++;
      $display("FAIL mask_release55: got %0d words last %h, required 2 words ending 55 from fifo 0",
               acc_data.size(), (acc_data.size() > 0) ? acc_data[acc_data.size()-1] : 8'h00);
    end
  endtask

  task automatic test_full_boundary();
    do_reset();
    pop_mask  = 2'b11;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) src0.push_back(8'(8'hC0 + k));
    drive_inputs();
    repeat (8) cycle();
    tests_run++;
    if (fifo_full !== 1'b1 || in_ready !== 2'b00 || push_log.size() != 4) begin
      tests_failed++;
      $display("FAIL full_fill: full=%b in_ready=%b pushes=%0d, required 1 00 4", fifo_full, in_ready, push_log.size());
    end
    pop_mask = 2'b00;
    cycle();
    tests_run++;
    if (pop_cnt != 1 || push_log.size() != 4) begin
      tests_failed++;
      $display("FAIL full_pop_first: pops=%0d pushes=%0d, required 1 4", pop_cnt, push_log.size());
    end
    cycle();
    tests_run++;
    if (push_log.size() != 5 || pop_cnt != 1) begin
      tests_failed++;
      $display("FAIL full_push_next: pushes=%0d pops=%0d, required 5 1", push_log.size(), pop_cnt);
    end
    for (int c = 0; c < 40 && acc_data.size() < 6; c++) cycle();
    tests_run++;
    if (acc_data.size() != 6) begin
      tests_failed++;
      $display("FAIL full_drain_count: got %0d words, required 6", acc_data.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests_run++;
        if (acc_data[k] !== 8'(8'hC0 + k) || acc_fifo[k] != 0) begin
          tests_failed++;
          $display("FAIL full_drain%0d: got %h fifo %0d, required %h fifo 0", k, acc_data[k], acc_fifo[k], 8'(8'hC0 + k));
        end
      end
    end
  endtask

  task automatic test_random();
    bit drained;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && src0.size() < 3) src0.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0 && src1.size() < 3) src1.push_back(8'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 2) != 0);
      pop_mask  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      drive_inputs();
      cycle();
    end
    out_ready = 1'b1;
    pop_mask  = 2'b00;
    drained   = 1'b0;
    for (int c = 0; c < 200 && !drained; c++) begin
      if (src0.size() == 0 && src1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 && !out_valid)
        drained = 1'b1;
      else
        cycle();
    end
    tests_run++;
    if (!drained || exp0.size() != 0 || exp1.size() != 0) begin
      tests_failed++;
      $display("FAIL random_drain: words left fifo0=%0d fifo1=%0d out_valid=%b, required all delivered",
               exp0.size(), exp1.size(), out_valid);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 2'b00;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    pop_mask  = 2'b00;
    test_reset();
    test_single_stream();
    test_round_robin();
    test_backpressure();
    test_pop_mask();
    test_full_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
